// File: rtl/serial_block_subtractor.sv
// serial_block_subtractor
//
// Block-serial two's-complement subtractor. It computes A - B - iBorrow one
// BLOCK_WIDTH slice per clock, least-significant slice first. A registered
// borrow carries from each slice into the next. Valid/ready handshakes on
// both sides let the block sit in a streaming datapath.
//
// Parameters
//   WIDTH        operand/result width; must be a multiple of BLOCK_WIDTH
//   BLOCK_WIDTH  bits processed per cycle; N = WIDTH/BLOCK_WIDTH slices
//
// Optional feature (macro SUB_OVERFLOW_EN)
//   When defined, the oOvf port and the signed-overflow flag are added.
//   When undefined, neither the port nor the logic exists.
//
// Ports
//   iClk     in   clock, rising edge
//   iRstn    in   asynchronous active-low reset
//   iValid   in   operand valid
//   oReady   out  operand accept (high only in IDLE)
//   iA       in   minuend
//   iB       in   subtrahend
//   iBorrow  in   borrow-in, subtracted at bit 0
//   oValid   out  result valid (DONE)
//   iReady   in   result accept by downstream
//   oD       out  A - B - iBorrow mod 2^WIDTH; defined only while oValid=1
//   oBorrow  out  1 iff unsigned A < B + iBorrow
//   oOvf     out  signed overflow (SUB_OVERFLOW_EN only)
//
// Latency is N cycles from accept to oValid. The minimum issue interval
// is N+2 cycles.

module serial_block_subtractor #(
    parameter int WIDTH       = 32,
    parameter int BLOCK_WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRstn,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iBorrow,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oD,
`ifdef SUB_OVERFLOW_EN
    output logic             oOvf,
`endif
    output logic             oBorrow
);

    localparam int N  = WIDTH / BLOCK_WIDTH;
    localparam int KW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state_q;
    logic [WIDTH-1:0]       a_q, b_q, d_q, d_d;
    logic                   bin_q;      // running borrow between slices
    logic [KW-1:0]          k_q;        // current slice index
    logic                   valid_q, ready_q, borrow_q;

    logic [BLOCK_WIDTH-1:0] a_sl, b_sl;
    logic [BLOCK_WIDTH:0]   sub;        // {borrow-out, slice difference}
    logic                   last_slice;

`ifdef SUB_OVERFLOW_EN
    logic                   ovf_q;
    logic                   ovf_d;
`endif

    // Slice select and the single BLOCK_WIDTH subtract cell. Slice k of the
    // result is merged into d_d while all other slices are kept.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                a_sl = a_q[i*BLOCK_WIDTH +: BLOCK_WIDTH];
                b_sl = b_q[i*BLOCK_WIDTH +: BLOCK_WIDTH];
            end
        end
        // The zero-extended subtract wraps negative exactly when a borrow
        // leaves the slice, so the top bit is the new borrow.
        sub = {1'b0, a_sl} - {1'b0, b_sl} - {{BLOCK_WIDTH{1'b0}}, bin_q};
        d_d = d_q;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                d_d[i*BLOCK_WIDTH +: BLOCK_WIDTH] = sub[BLOCK_WIDTH-1:0];
            end
        end
        last_slice = (k_q == KW'(N - 1));
    end

`ifdef SUB_OVERFLOW_EN
    // The result MSB is produced by the top slice, which is the one being
    // computed when last_slice is high.
    assign ovf_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) &
                   (sub[BLOCK_WIDTH-1] ^ a_q[WIDTH-1]);
`endif

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            bin_q    <= 1'b0;
            k_q      <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            borrow_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (iValid) begin
                        a_q     <= iA;
                        b_q     <= iB;
                        bin_q   <= iBorrow;
                        k_q     <= '0;
                        ready_q <= 1'b0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    d_q   <= d_d;
                    bin_q <= sub[BLOCK_WIDTH];
                    if (last_slice) begin
                        borrow_q <= sub[BLOCK_WIDTH];
`ifdef SUB_OVERFLOW_EN
                        ovf_q    <= ovf_d;
`endif
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    // Results hold until downstream takes them; new
                    // operands are not considered here.
                    if (iReady) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign oReady  = ready_q;
    assign oValid  = valid_q;
    assign oD      = d_q;
    assign oBorrow = borrow_q;
`ifdef SUB_OVERFLOW_EN
    assign oOvf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_block_subtractor.sv
module tb_serial_block_subtractor;

    logic        iClk = 1'b0;
    logic        iRstn = 1'b0;
    logic        iValid = 1'b0;
    logic        oReady;
    logic [31:0] iA = '0;
    logic [31:0] iB = '0;
    logic        iBorrow = 1'b0;
    logic        oValid;
    logic        iReady = 1'b1;
    logic [31:0] oD;
    logic        oBorrow;
`ifdef SUB_OVERFLOW_EN
    logic        oOvf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 iClk = ~iClk;

    serial_block_subtractor #(.WIDTH(32), .BLOCK_WIDTH(8)) dut (
        .iClk    (iClk),
        .iRstn   (iRstn),
        .iValid  (iValid),
        .oReady  (oReady),
        .iA      (iA),
        .iB      (iB),
        .iBorrow (iBorrow),
        .oValid  (oValid),
        .iReady  (iReady),
        .oD      (oD),
`ifdef SUB_OVERFLOW_EN
        .oOvf    (oOvf),
`endif
        .oBorrow (oBorrow)
    );

    // Stimulus only: present operands for one edge, then count the
    // negedges until oValid (bounded; 50 means it never came).
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic bin, output int lat);
        @(negedge iClk);
        iValid = 1'b1; iA = a; iB = b; iBorrow = bin;
        @(posedge iClk);
        @(negedge iClk);
        iValid = 1'b0;
        lat = 0;
        while (oValid !== 1'b1 && lat < 50) begin
            @(negedge iClk);
            lat++;
        end
    endtask

    task automatic test_reset;
        iRstn = 1'b0;
        repeat (2) @(negedge iClk);
        total++; if (oValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", oValid); end
        total++; if (oReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", oReady); end
        total++; if (oD !== 32'h0) begin bad++; $display("FAIL reset_d got=%h exp=00000000", oD); end
        total++; if (oBorrow !== 1'b0) begin bad++; $display("FAIL reset_borrow got=%b exp=0", oBorrow); end
`ifdef SUB_OVERFLOW_EN
        total++; if (oOvf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", oOvf); end
`endif
        iRstn = 1'b1;
        @(negedge iClk);
    endtask

    task automatic test_basic;
        logic [31:0] va [4] = '{32'h0000_0005, 32'h0000_0000, 32'h0000_0100, 32'h0000_0000};
        logic [31:0] vb [4] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
        logic        vi [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] ed [4] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FFFF};
        logic        eb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int lat;
        iReady = 1'b1;
        for (int v = 0; v < 4; v++) begin
            total++; if (oReady !== 1'b1) begin bad++; $display("FAIL basic%0d_ready_before got=%b exp=1", v, oReady); end
            issue(va[v], vb[v], vi[v], lat);
            total++; if (lat !== 4) begin bad++; $display("FAIL basic%0d_latency got=%0d exp=4", v, lat); end
            total++; if (oD !== ed[v]) begin bad++; $display("FAIL basic%0d_d got=%h exp=%h", v, oD, ed[v]); end
            total++; if (oBorrow !== eb[v]) begin bad++; $display("FAIL basic%0d_borrow got=%b exp=%b", v, oBorrow, eb[v]); end
`ifdef SUB_OVERFLOW_EN
            total++; if (oOvf !== 1'b0) begin bad++; $display("FAIL basic%0d_ovf got=%b exp=0", v, oOvf); end
`endif
            total++; if (oReady !== 1'b0) begin bad++; $display("FAIL basic%0d_ready_done got=%b exp=0", v, oReady); end
            @(negedge iClk);
            total++; if (oValid !== 1'b0) begin bad++; $display("FAIL basic%0d_valid_drop got=%b exp=0", v, oValid); end
            total++; if (oReady !== 1'b1) begin bad++; $display("FAIL basic%0d_ready_back got=%b exp=1", v, oReady); end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        iReady = 1'b0;
        issue(32'h0001_0000, 32'h0000_0001, 1'b0, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL bp_latency got=%0d exp=4", lat); end
        for (int c = 0; c < 3; c++) begin
            iValid = 1'b1; iA = 32'hFFFF_FFFF; iB = 32'h0; iBorrow = 1'b0;
            @(negedge iClk);
            total++; if (oValid !== 1'b1) begin bad++; $display("FAIL bp%0d_valid got=%b exp=1", c, oValid); end
            total++; if (oD !== 32'h0000_FFFF) begin bad++; $display("FAIL bp%0d_d got=%h exp=0000ffff", c, oD); end
            total++; if (oBorrow !== 1'b0) begin bad++; $display("FAIL bp%0d_borrow got=%b exp=0", c, oBorrow); end
            total++; if (oReady !== 1'b0) begin bad++; $display("FAIL bp%0d_ready got=%b exp=0", c, oReady); end
        end
        iValid = 1'b0;
        iReady = 1'b1;
        @(negedge iClk);
        total++; if (oValid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", oValid); end
        total++; if (oReady !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", oReady); end
        @(negedge iClk);
        total++; if (oReady !== 1'b1) begin bad++; $display("FAIL bp_not_accepted got=%b exp=1", oReady); end
    endtask

    task automatic test_reset_mid;
        int lat;
        @(negedge iClk);
        iValid = 1'b1; iA = 32'h1234_5678; iB = 32'h1111_1111; iBorrow = 1'b0;
        @(posedge iClk);
        @(negedge iClk);
        iValid = 1'b0;
        @(posedge iClk);
        @(posedge iClk);
        #2;
        iRstn = 1'b0;
        #1;
        total++; if (oValid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", oValid); end
        total++; if (oReady !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", oReady); end
        total++; if (oD !== 32'h0) begin bad++; $display("FAIL rmid_d got=%h exp=00000000", oD); end
        total++; if (oBorrow !== 1'b0) begin bad++; $display("FAIL rmid_borrow got=%b exp=0", oBorrow); end
        @(negedge iClk);
        iRstn = 1'b1;
        @(negedge iClk);
        issue(32'h0000_000A, 32'h0000_0004, 1'b0, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL rmid_after_latency got=%0d exp=4", lat); end
        total++; if (oD !== 32'h0000_0006) begin bad++; $display("FAIL rmid_after_d got=%h exp=00000006", oD); end
        total++; if (oBorrow !== 1'b0) begin bad++; $display("FAIL rmid_after_borrow got=%b exp=0", oBorrow); end
        @(negedge iClk);
    endtask

`ifdef SUB_OVERFLOW_EN
    task automatic test_overflow;
        int lat;
        issue(32'h8000_0000, 32'h0000_0001, 1'b0, lat);
        total++; if (oD !== 32'h7FFF_FFFF) begin bad++; $display("FAIL ovf1_d got=%h exp=7fffffff", oD); end
        total++; if (oOvf !== 1'b1) begin bad++; $display("FAIL ovf1_ovf got=%b exp=1", oOvf); end
        total++; if (oBorrow !== 1'b0) begin bad++; $display("FAIL ovf1_borrow got=%b exp=0", oBorrow); end
        @(negedge iClk);
        issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
        total++; if (oD !== 32'h8000_0000) begin bad++; $display("FAIL ovf2_d got=%h exp=80000000", oD); end
        total++; if (oOvf !== 1'b1) begin bad++; $display("FAIL ovf2_ovf got=%b exp=1", oOvf); end
        total++; if (oBorrow !== 1'b1) begin bad++; $display("FAIL ovf2_borrow got=%b exp=1", oBorrow); end
        @(negedge iClk);
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_reset_mid;
`ifdef SUB_OVERFLOW_EN
        test_overflow;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
